lzc_reg: RTL and testbench
==========================

Name: lzc_reg

Overview:
- Registered leading-zero counter for the fixed-point reciprocal datapath.
- Counts the zero bits above the most-significant set bit of an unsigned magnitude word, default 24 bits (SQ12.12 magnitude).
- The reciprocal normaliser uses the count to shift its operand into the [0.5,1) range: shift = M - count.
- One-cycle latency, with a valid flag travelling alongside the data.

Parameters:
- WIDTH, 24: input word width in bits (M+N of the host fixed-point format); legal range 2..64.
- CW, $clog2(WIDTH+1): count width; derived, must not be overridden. Default gives 5.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  i_data is valid this cycle.
- i_data  input  WIDTH  unsigned magnitude to count; bit WIDTH-1 is the MSB.
- o_valid  output  1  o_lzc/o_zero are valid this cycle.
- o_lzc  output  CW  number of leading zeros of the captured word.
- o_zero  output  1  captured word was all zeros.

Behaviour:
- Reset:
  - While i_reset_n=0, all outputs are forced immediately (asynchronously) to 0: o_valid=0, o_lzc=0, o_zero=0.
  - Release is sampled synchronously. The first capture is possible on the first rising edge with i_reset_n=1.
- Count function: o_lzc = WIDTH-1-k, where k is the index of the highest set bit of i_data.
  - MSB set gives 0.
  - Only bit 0 set gives WIDTH-1.
- All-zero input: o_lzc = WIDTH (24 by default) and o_zero=1. For any nonzero input, o_zero=0.
- Latency and handshake:
  - On every rising edge, o_valid <= i_valid.
  - When i_valid=1, o_lzc and o_zero are loaded from the combinational count of i_data.
  - When i_valid=0, o_lzc and o_zero hold their previous values; only o_valid drops.
  - No backpressure. A new word may be accepted every cycle, so back-to-back valids give back-to-back results.
- Reset mid-stream: any in-flight result is discarded. After release, o_valid stays 0 until a new i_valid.
- Combinational path: the count is computed with a balanced priority/OR tree (log2 depth), not a linear chain, so that the 24-bit case fits one cycle.
- No X propagation: with i_valid=1, every input value, including all-zero, produces a defined count.
- Integration: the reciprocal block consuming o_lzc must add one pipeline stage to its operand path so that data and count stay aligned.

Decomposition:
- Shared package (e.g. rbz_fixed_pkg) holds:
  - M=12, N=12, and the derived word width M+N.
  - A constant function clog2 used to size CW.
  - A typedef for the count type.
- Natural sub-module: lzc_tree, purely combinational, parameter WIDTH.
  - Inputs: data. Outputs: count and all_zero.
  - Built recursively: split the word in halves, then combine the half-results as (upper all-zero ? WIDTH_hi + lower count : upper count).
- lzc_reg wraps lzc_tree with the output registers and the valid flop.

Test Plan:
- Reset: hold i_reset_n=0, then apply i_valid=1, i_data=0x800000 -> o_valid=0, o_lzc=0, o_zero=0 throughout reset. Deassert -> next edge o_valid=1, o_lzc=0.
- SQ12.12 1.0, single valid: i_data=0x001000 -> one edge later o_lzc=11, o_zero=0, o_valid=1. Following cycle with i_valid=0 -> o_valid=0, o_lzc still 11.
- Extremes back-to-back, one per cycle: 0x000001, 0x7FFFFF, 0xFFFFFF, 0x000000 -> successive o_lzc 23, 1, 0, 24. o_zero is 1 only for the last. o_valid=1 for four consecutive cycles.
- Exhaustive walking one: for k=0..23, i_data=1<<k (with random lower bits below k on a second pass) -> o_lzc=23-k every time.
- Async reset mid-stream: stream valid words, drop i_reset_n between clock edges -> outputs go to 0 before the next edge. After release without i_valid, o_valid stays 0.
- Random compare: 10k random words with random i_valid against a behavioural model of the count function; also run WIDTH=8 (0x01 -> 7, 0x00 -> 8, CW=4).

Source files
------------

// File: rtl/lzc_reg_pkg.sv
// Shared fixed-point constants and sizing helpers for the reciprocal datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
package lzc_reg_pkg;

  // Host fixed-point format: SQ12.12 magnitude
  localparam int M      = 12;
  localparam int N      = 12;
  localparam int WORD_W = M + N;

  // Ceiling log2, usable in constant expressions for sizing counts
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int x = value - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Width of a leading-zero count for the default word (must hold 0..WORD_W)
  localparam int COUNT_W = clog2(WORD_W + 1);

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero count built as a balanced recursive half-split tree.
// Latency: 0 cycles (pure combinational), depth grows with log2(WIDTH).
// Backpressure: none.
module lzc_tree
  import lzc_reg_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  localparam int CW    = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count,
  output logic             o_all_zero
);

  generate
    if (WIDTH == 1) begin : g_leaf
      // A single bit: one leading zero exactly when it is clear
      assign o_count    = ~i_data;
      assign o_all_zero = ~i_data[0];
    end else begin : g_split
      localparam int W_HI  = WIDTH / 2;
      localparam int W_LO  = WIDTH - W_HI;
      localparam int CW_HI = clog2(W_HI + 1);
      localparam int CW_LO = clog2(W_LO + 1);

      logic [CW_HI-1:0] w_hi_cnt;
      logic [CW_LO-1:0] w_lo_cnt;
      logic             w_hi_zero;
      logic             w_lo_zero;

      lzc_tree #(.WIDTH(W_HI)) u_hi (
        .i_data     (i_data[WIDTH-1 -: W_HI]),
        .o_count    (w_hi_cnt),
        .o_all_zero (w_hi_zero)
      );

      lzc_tree #(.WIDTH(W_LO)) u_lo (
        .i_data     (i_data[W_LO-1:0]),
        .o_count    (w_lo_cnt),
        .o_all_zero (w_lo_zero)
      );

      // Upper half empty: every upper bit is a leading zero, continue into lower half.
      // When both halves are empty this yields W_HI + W_LO = WIDTH.
      assign o_all_zero = w_hi_zero & w_lo_zero;
      assign o_count    = w_hi_zero ? (CW'(W_HI) + CW'(w_lo_cnt)) : CW'(w_hi_cnt);
    end
  endgenerate

endmodule

// File: rtl/lzc_reg.sv
// Registered leading-zero counter; feeds shift = M - count to the reciprocal normaliser.
// Latency: 1 cycle, o_valid travels with o_lzc/o_zero; results hold while i_valid is low.
// Backpressure: none, one word accepted every cycle.
module lzc_reg
  import lzc_reg_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  localparam int CW    = clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [CW-1:0]    o_lzc,
  output logic             o_zero
);

  logic [CW-1:0] w_count;
  logic          w_all_zero;
  logic          r_valid;
  logic [CW-1:0] r_lzc;
  logic          r_zero;

  lzc_tree #(.WIDTH(WIDTH)) u_tree (
    .i_data     (i_data),
    .o_count    (w_count),
    .o_all_zero (w_all_zero)
  );

  // Valid follows input every edge; count/zero load only on a valid word and hold otherwise
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_lzc   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_lzc  <= w_count;
        r_zero <= w_all_zero;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_lzc   = r_lzc;
  assign o_zero  = r_zero;

endmodule

// File: tb/tb_lzc_reg.sv
// Self-checking bench for lzc_reg at WIDTH=24 and WIDTH=8.
// Latency: expects results one edge after capture.
// Backpressure: none exercised.
module tb_lzc_reg;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [23:0] i_data;
  logic [7:0]  i_data8;
  logic        o_valid;
  logic [4:0]  o_lzc;
  logic        o_zero;
  logic        o_valid8;
  logic [3:0]  o_lzc8;
  logic        o_zero8;

  int n_checks = 0;
  int n_errors = 0;

  lzc_reg #(.WIDTH(24)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_lzc     (o_lzc),
    .o_zero    (o_zero)
  );

  lzc_reg #(.WIDTH(8)) dut8 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data8),
    .o_valid   (o_valid8),
    .o_lzc     (o_lzc8),
    .o_zero    (o_zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference count: scan from the top bit down for the first one
  function automatic int lzc_model(input int w, input logic [63:0] d);
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i]) return w - 1 - i;
    end
    return w;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs: one-cycle delayed view of the inputs, cleared by reset
  int exp_valid, exp_lzc, exp_zero;
  int exp_lzc8, exp_zero8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 0;
      exp_lzc   <= 0;
      exp_zero  <= 0;
      exp_lzc8  <= 0;
      exp_zero8 <= 0;
    end else begin
      exp_valid <= int'(i_valid);
      if (i_valid) begin
        exp_lzc   <= lzc_model(24, 64'(i_data));
        exp_zero  <= (i_data == 24'd0) ? 1 : 0;
        exp_lzc8  <= lzc_model(8, 64'(i_data8));
        exp_zero8 <= (i_data8 == 8'd0) ? 1 : 0;
      end
    end
  end

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("cmp_valid",  o_valid,  exp_valid);
    chk("cmp_lzc",    o_lzc,    exp_lzc);
    chk("cmp_zero",   o_zero,   exp_zero);
    chk("cmp_valid8", o_valid8, exp_valid);
    chk("cmp_lzc8",   o_lzc8,   exp_lzc8);
    chk("cmp_zero8",  o_zero8,  exp_zero8);
  end

  // Apply inputs, let one rising edge capture them, return just after that edge
  task automatic step(input logic v, input logic [23:0] d, input logic [7:0] d8);
    i_valid = v;
    i_data  = d;
    i_data8 = d8;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rand_word();
    logic [23:0] w;
    w = 24'($urandom);
    if ($urandom_range(0, 15) == 0) return 24'd0;
    return w >> $urandom_range(0, 23);
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom);
    return b >> $urandom_range(0, 8);
  endfunction

  initial begin
    logic [23:0] ext [4];
    int          ext_lzc [4];
    logic [23:0] w;

    ext[0] = 24'h000001; ext_lzc[0] = 23;
    ext[1] = 24'h7FFFFF; ext_lzc[1] = 1;
    ext[2] = 24'hFFFFFF; ext_lzc[2] = 0;
    ext[3] = 24'h000000; ext_lzc[3] = 24;

    // Reset held with a valid word presented: outputs must stay at zero
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_data  = 24'h800000;
    i_data8 = 8'h80;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_lzc",   o_lzc,   0);
      chk("rst_zero",  o_zero,  0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_valid", o_valid, 1);
    chk("rel_lzc",   o_lzc,   0);
    chk("rel_zero",  o_zero,  0);

    // 1.0 in SQ12.12, then an idle cycle that must hold the count
    step(1'b1, 24'h001000, 8'h01);
    chk("one_valid", o_valid, 1);
    chk("one_lzc",   o_lzc,   11);
    chk("one_zero",  o_zero,  0);
    chk("w8_lzc_01", o_lzc8,  7);
    step(1'b0, 24'hABCDEF, 8'h00);
    chk("idle_valid", o_valid, 0);
    chk("idle_lzc",   o_lzc,   11);
    chk("idle_zero",  o_zero,  0);

    // Extremes back-to-back
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ext[i], 8'h00);
      chk("ext_valid", o_valid, 1);
      chk("ext_lzc",   o_lzc,   ext_lzc[i]);
      chk("ext_zero",  o_zero,  (i == 3) ? 1 : 0);
    end
    chk("w8_lzc_00",  o_lzc8,  8);
    chk("w8_zero_00", o_zero8, 1);

    // Walking one, clean then with random bits below the leading one
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 24; k++) begin
        w = 24'd1 << k;
        if (pass == 1) w = w | (24'($urandom) & (w - 24'd1));
        step(1'b1, w, rand_byte());
        chk("walk_lzc",  o_lzc,  23 - k);
        chk("walk_zero", o_zero, 0);
      end
    end

    // Asynchronous reset dropped between edges in the middle of a stream
    for (int i = 0; i < 3; i++) step(1'b1, rand_word(), rand_byte());
    step(1'b1, 24'h000010, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_lzc",   o_lzc,   0);
    chk("arst_zero",  o_zero,  0);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 24'h800000, 8'h80);
    chk("post_rel_valid", o_valid, 0);
    step(1'b0, 24'h000001, 8'h01);
    chk("post_rel_valid2", o_valid, 0);
    chk("post_rel_lzc",    o_lzc,   0);

    // Random stream, checked every cycle by the compare process
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), rand_word(), rand_byte());
    end

    step(1'b0, 24'd0, 8'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
